envelope_avg_unit: RTL

//  Upstream neighbour of the cutoff-frequency stage: produces env_avg from the raw audio stream.

---
 rtl/envelope_avg_unit_if.sv | 24 ++
 rtl/envelope_avg_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/envelope_avg_unit_if.sv
// Sample-in / envelope-out bundle between the audio source, the envelope
// averager and the cutoff-frequency stage.
interface envelope_avg_unit_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic signed [SAMPLE_WIDTH-1:0] sample_in;
   logic                           sample_valid;
   logic                           clear;
   logic        [SAMPLE_WIDTH-1:0] env_avg;
   logic                           env_valid;
   logic                           window_full;

   // Producer side: drives samples and flush, observes the envelope.
   modport master (
      output sample_in, sample_valid, clear,
      input  env_avg, env_valid, window_full
   );

   // Averager side.
   modport slave (
      input  sample_in, sample_valid, clear,
      output env_avg, env_valid, window_full
   );
endinterface

// File: rtl/envelope_avg_unit.sv
// Envelope follower: rectifies each signed sample and keeps a boxcar moving
// average of the last 2**LOG2_WIN magnitudes (circular buffer + running sum).
// Two-stage pipeline: stage 1 rectifies, stage 2 updates sum/buffer/output.
module envelope_avg_unit #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int LOG2_WIN     = 4
) (
   input  logic                clk,
   input  logic                rst,
   envelope_avg_unit_if.slave  bus
);
   localparam int SW   = SAMPLE_WIDTH;
   localparam int MW   = SW - 1;            // magnitude width after saturation
   localparam int SUMW = SW + LOG2_WIN;     // running sum never overflows
   localparam int WIN  = 1 << LOG2_WIN;
   localparam logic [LOG2_WIN:0] WIN_CNT = {1'b1, {LOG2_WIN{1'b0}}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Stage 1 registers
   logic [MW-1:0]       mag_reg;
   logic                s1_valid_reg;

   // Stage 2 state
   logic [MW-1:0]       mag_buf [WIN];
   logic [LOG2_WIN-1:0] wr_ptr_reg;
   logic [LOG2_WIN:0]   count_reg;
   logic [SUMW-1:0]     sum_reg;
   state_t              state_reg;
   logic [SW-1:0]       env_avg_reg;
   logic                env_valid_reg;
   logic                window_full_reg;

   // Combinational helpers
   logic [SW-1:0]       sample_neg;
   logic [MW-1:0]       mag_next;
   logic [MW-1:0]       old_mag;
   logic [SUMW-1:0]     sum_next;

   assign sample_neg = ~bus.sample_in + 1'b1;

   // Rectify; the most negative code saturates to the largest positive magnitude.
   always_comb begin
      mag_next = bus.sample_in[MW-1:0];
      if (bus.sample_in[SW-1]) begin
         if (bus.sample_in[MW-1:0] == '0)
            mag_next = {MW{1'b1}};
         else
            mag_next = sample_neg[MW-1:0];
      end
   end

   // Until the window has wrapped once, the slot being overwritten holds
   // stale data that was never added, so nothing is subtracted.
   always_comb begin
      old_mag  = (state_reg == FULL) ? mag_buf[wr_ptr_reg] : '0;
      sum_next = sum_reg + {{(SUMW-MW){1'b0}}, mag_reg}
                         - {{(SUMW-MW){1'b0}}, old_mag};
   end

   // Window storage: plain memory, intentionally not reset.
   always_ff @(posedge clk) begin
      if (s1_valid_reg && !bus.clear)
         mag_buf[wr_ptr_reg] <= mag_reg;
   end

   // Pipeline, running sum, fill-state FSM and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_reg         <= '0;
         s1_valid_reg    <= 1'b0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         sum_reg         <= '0;
         state_reg       <= EMPTY;
         env_avg_reg     <= '0;
         env_valid_reg   <= 1'b0;
         window_full_reg <= 1'b0;
      end else if (bus.clear) begin
         s1_valid_reg    <= 1'b0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         sum_reg         <= '0;
         state_reg       <= EMPTY;
         env_avg_reg     <= '0;
         env_valid_reg   <= 1'b0;
         window_full_reg <= 1'b0;
      end else begin
         s1_valid_reg  <= bus.sample_valid;
         if (bus.sample_valid)
            mag_reg <= mag_next;

         env_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            sum_reg     <= sum_next;
            wr_ptr_reg  <= wr_ptr_reg + 1'b1;
            env_avg_reg <= sum_next[LOG2_WIN +: SW];
            case (state_reg)
               EMPTY: begin
                  count_reg <= {{LOG2_WIN{1'b0}}, 1'b1};
                  state_reg <= FILL;
               end
               FILL: begin
                  count_reg <= count_reg + 1'b1;
                  if (count_reg + 1'b1 == WIN_CNT) begin
                     state_reg       <= FULL;
                     window_full_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg <= FULL;
               end
            endcase
         end
      end
   end

   assign bus.env_avg     = env_avg_reg;
   assign bus.env_valid   = env_valid_reg;
   assign bus.window_full = window_full_reg;
endmodule
